// File: rtl/request_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : request_dispatcher
//  Description : Drains request_queue in arrival order. Stored slot ids are
//                kept in an order FIFO, popped from the queue, and the
//                returned payload is presented with its slot id on a
//                valid/ready stream through a 2-entry output buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module request_dispatcher #(
  parameter int DATA_WIDTH = 8,
  parameter int LSIZE      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  slot_valid_in,
  input  logic [LSIZE-1:0]      slot_id_in,
  output logic                  pop_en_out,
  output logic [LSIZE-1:0]      pop_slot_id_out,
  input  logic [DATA_WIDTH-1:0] pop_data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [LSIZE-1:0]      out_slot_id,
  output logic [LSIZE:0]        pending_count,
  output logic                  error
);

  localparam int            DEPTH    = 2 ** LSIZE;
  localparam logic [LSIZE:0] FULL_CNT = {1'b1, {LSIZE{1'b0}}};

  // Order FIFO storage and pointers
  logic [LSIZE-1:0] fifo_mem_q [DEPTH];
  logic [LSIZE-1:0] wr_ptr_q, rd_ptr_q;
  logic [LSIZE:0]   cnt_q, cnt_d;
  logic             error_q;

  // Issue stage: one pop may be outstanding while the queue RAM read lands
  logic             inflight_q;
  logic [LSIZE-1:0] id_dly_q;

  // Two-entry output buffer
  logic [DATA_WIDTH-1:0] obuf_data_q [2];
  logic [LSIZE-1:0]      obuf_id_q   [2];
  logic                  ohead_q;
  logic [1:0]            ocnt_q, ocnt_d;

  logic       fifo_empty, fifo_full, push_ok, deq, enq, otail;
  logic [2:0] occ;

  // Issue decision, FIFO/buffer bookkeeping and output muxing
  always_comb begin
    fifo_empty      = (cnt_q == '0);
    fifo_full       = (cnt_q == FULL_CNT);
    push_ok         = slot_valid_in && !fifo_full;
    out_valid       = (ocnt_q != 2'd0);
    deq             = out_valid && out_ready;
    enq             = inflight_q;
    // Buffer occupancy after this cycle's dequeue, counting the pending read;
    // using the same-cycle dequeue lets a pop issue every cycle under ready.
    occ             = {1'b0, ocnt_q} + {2'b00, inflight_q} - {2'b00, deq};
    pop_en_out      = !fifo_empty && (occ < 3'd2);
    pop_slot_id_out = fifo_empty ? '0 : fifo_mem_q[rd_ptr_q];
    cnt_d           = cnt_q + {{LSIZE{1'b0}}, push_ok} - {{LSIZE{1'b0}}, pop_en_out};
    ocnt_d          = ocnt_q + {1'b0, enq} - {1'b0, deq};
    // With two entries held the tail index coincides with the head slot,
    // which is only written when that head is being dequeued.
    otail           = ohead_q ^ ocnt_q[0];
    out_data        = out_valid ? obuf_data_q[ohead_q] : '0;
    out_slot_id     = out_valid ? obuf_id_q[ohead_q]   : '0;
    pending_count   = cnt_q;
    error           = error_q;
  end

  // Order FIFO storage write; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem_q[wr_ptr_q] <= slot_id_in;
    end
  end

  // Order FIFO pointers, count and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_en_out) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      cnt_q <= cnt_d;
      if (slot_valid_in && fifo_full) begin
        error_q <= 1'b1;
      end
    end
  end

  // Track the outstanding queue read and the slot id it belongs to
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= 1'b0;
      id_dly_q   <= '0;
    end else begin
      inflight_q <= pop_en_out;
      id_dly_q   <= pop_slot_id_out;
    end
  end

  // Output buffer: capture returned payload at the tail, retire at the head
  always_ff @(posedge clk) begin
    if (reset) begin
      ohead_q        <= 1'b0;
      ocnt_q         <= 2'd0;
      obuf_data_q[0] <= '0;
      obuf_data_q[1] <= '0;
      obuf_id_q[0]   <= '0;
      obuf_id_q[1]   <= '0;
    end else begin
      if (enq) begin
        obuf_data_q[otail] <= pop_data_in;
        obuf_id_q[otail]   <= id_dly_q;
      end
      if (deq) begin
        ohead_q <= ~ohead_q;
      end
      ocnt_q <= ocnt_d;
    end
  end

endmodule
`default_nettype wire
